// File: rtl/chip_ctrl_apb_regs.sv
// rtl/chip_ctrl_apb_regs.sv - chip-control APB3 register slave with glitch-free clock-enable divider
module chip_ctrl_apb_regs #(
  parameter logic [31:0] CHIP_ID      = 32'h5050_0001,
  parameter logic [31:0] PADMUX_RESET = 32'h0,
  parameter logic [7:0]  DIV_RESET    = 8'd3
) (
  input  logic        soc_clk_i,
  input  logic        soc_rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [11:0] paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic [2:0]  pprot_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [31:0] padmux_o,
  output logic        clk_en_o,
  output logic        div_busy_o
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_STALL} state_t;

  state_t      state_q, state_d;
  logic [31:0] padmux_q, padmux_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] prdata_q, prdata_d;
  logic        rd_err_q, rd_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  div_active_q, div_active_d;
  logic [7:0]  div_pending_q, div_pending_d;
  logic        div_busy_q, div_busy_d;

  logic        access;
  logic        addr_ok;
  logic        sel_div;
  logic        wr_err;
  logic        wr_do;
  logic        boundary;
  logic [31:0] rdata_mux;
  logic        unused_inputs;

  // Protection bits and byte-lane address bits carry no meaning here.
  assign unused_inputs = ^{pprot_i, paddr_i[1:0]};

  assign access   = psel_i & penable_i;
  assign addr_ok  = (paddr_i[11:4] == 8'h00);
  assign sel_div  = addr_ok && (paddr_i[3:2] == 2'd2);
  // Unmapped addresses and the read-only INFO word reject writes.
  assign wr_err   = !addr_ok || (paddr_i[3:2] == 2'd0);
  assign boundary = (cnt_q == div_active_q);

  assign prdata_o   = prdata_q;
  assign padmux_o   = padmux_q;
  assign clk_en_o   = boundary;
  assign div_busy_o = div_busy_q;

  // Read data selection; unmapped addresses read as zero.
  always_comb begin
    rdata_mux = 32'h0;
    if (addr_ok) begin
      case (paddr_i[3:2])
        2'd0:    rdata_mux = CHIP_ID;
        2'd1:    rdata_mux = padmux_q;
        2'd2:    rdata_mux = {23'b0, div_busy_q, div_active_q};
        default: rdata_mux = scratch_q;
      endcase
    end
  end

  // APB handshake: reads take one wait state, a CLKDIV write stalls while an update is pending.
  always_comb begin
    state_d   = state_q;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    wr_do     = 1'b0;
    prdata_d  = prdata_q;
    rd_err_d  = rd_err_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (!pwrite_i) begin
            prdata_d = rdata_mux;
            rd_err_d = !addr_ok;
            state_d  = RD_WAIT;
          end else if (sel_div && div_busy_q) begin
            state_d = WR_STALL;
          end else begin
            pready_o  = 1'b1;
            pslverr_o = wr_err;
            wr_do     = !wr_err;
          end
        end
      end
      RD_WAIT: begin
        pready_o  = 1'b1;
        pslverr_o = rd_err_q;
        state_d   = IDLE;
      end
      WR_STALL: begin
        if (!div_busy_q) begin
          pready_o = 1'b1;
          wr_do    = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register writes and the divider; a pending ratio is only adopted on a period boundary.
  always_comb begin
    padmux_d      = padmux_q;
    scratch_d     = scratch_q;
    div_active_d  = div_active_q;
    div_pending_d = div_pending_q;
    div_busy_d    = div_busy_q;
    cnt_d         = boundary ? 8'd0 : cnt_q + 8'd1;
    if (boundary && div_busy_q) begin
      div_active_d = div_pending_q;
      div_busy_d   = 1'b0;
    end
    // A CLKDIV write is only performed while not busy, so it never races an apply.
    if (wr_do) begin
      case (paddr_i[3:2])
        2'd1: padmux_d = pwdata_i;
        2'd2: begin
          div_pending_d = pwdata_i[7:0];
          div_busy_d    = 1'b1;
        end
        2'd3: scratch_d = pwdata_i;
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge soc_clk_i or posedge soc_rst_i) begin
    if (soc_rst_i) begin
      state_q       <= IDLE;
      padmux_q      <= PADMUX_RESET;
      scratch_q     <= 32'h0;
      prdata_q      <= 32'h0;
      rd_err_q      <= 1'b0;
      cnt_q         <= 8'd0;
      div_active_q  <= DIV_RESET;
      div_pending_q <= DIV_RESET;
      div_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      padmux_q      <= padmux_d;
      scratch_q     <= scratch_d;
      prdata_q      <= prdata_d;
      rd_err_q      <= rd_err_d;
      cnt_q         <= cnt_d;
      div_active_q  <= div_active_d;
      div_pending_q <= div_pending_d;
      div_busy_q    <= div_busy_d;
    end
  end

endmodule

// File: tb/tb_chip_ctrl_apb_regs.sv
// tb/tb_chip_ctrl_apb_regs.sv - self-checking bench for chip_ctrl_apb_regs
module tb_chip_ctrl_apb_regs;

  localparam logic [31:0] CHIP_ID = 32'h5050_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = 12'h0;
  logic [31:0] pwdata = 32'h0;
  logic [2:0]  pprot = 3'h0;
  logic [31:0] prdata, padmux;
  logic        pready, pslverr, clk_en, div_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_q[$];
  int apply_q[$];
  logic [31:0] m_padmux, m_scratch;

  chip_ctrl_apb_regs dut (
    .soc_clk_i(clk), .soc_rst_i(rst), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pprot_i(pprot),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .padmux_o(padmux), .clk_en_o(clk_en), .div_busy_o(div_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log; a pulse seen while busy is the one that adopts the pending ratio.
  always @(negedge clk) begin
    if (!rst && clk_en) begin
      pulse_q.push_back(cyc);
      if (div_busy) apply_q.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Called #1 after a posedge; returns #1 after the completing posedge, ready for the next setup.
  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int n);
    bit done;
    done = 0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pprot = 3'($urandom);
    @(posedge clk); #1;
    penable = 1'b1;
    n = 2;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pready) begin
        done = 1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    rd = prdata;
    err = pslverr;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL apb_timeout addr=%h got no pready want pready within 100 cycles", a);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset(output int rel);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    pulse_q.delete();
    apply_q.delete();
    m_padmux = 32'h0;
    m_scratch = 32'h0;
    rst = 1'b0;
    rel = cyc;
  endtask

  task automatic test_reset;
    int rel, n;
    logic [31:0] rd;
    logic err;
    do_reset(rel);
    checks++;
    if ({pready, pslverr, div_busy, clk_en} !== 4'b0000 || padmux !== 32'h0 || prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy/err/busy/en=%b padmux=%h prdata=%h want 0000 0 0",
               {pready, pslverr, div_busy, clk_en}, padmux, prdata);
    end
    apb(1'b0, 12'h000, 32'h0, rd, err, n);
    checks++;
    if (rd !== CHIP_ID || err !== 1'b0 || n !== 3) begin
      errors++;
      $display("FAIL reset_info got rd=%h err=%b n=%0d want %h 0 3", rd, err, n, CHIP_ID);
    end
    apb(1'b0, 12'h008, 32'h0, rd, err, n);
    checks++;
    if (rd !== 32'h0000_0003 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_clkdiv got rd=%h err=%b want 00000003 0", rd, err);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (pulse_q.size() < 3 || pulse_q[0] !== rel + 3) begin
      errors++;
      $display("FAIL reset_first_pulse got n=%0d first=%0d want >=3 pulses first=%0d",
               pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] - rel : -1, 3);
    end
    for (int j = 1; j < pulse_q.size(); j++) begin
      checks++;
      if (pulse_q[j] - pulse_q[j-1] !== 4) begin
        errors++;
        $display("FAIL reset_period got %0d want 4", pulse_q[j] - pulse_q[j-1]);
      end
    end
  endtask

  task automatic test_padmux;
    int n;
    logic [31:0] rd;
    logic err;
    apb(1'b1, 12'h004, 32'hA5A5_0F0F, rd, err, n);
    m_padmux = 32'hA5A5_0F0F;
    checks++;
    if (err !== 1'b0 || n !== 2 || padmux !== m_padmux) begin
      errors++;
      $display("FAIL padmux_write got err=%b n=%0d padmux=%h want 0 2 %h", err, n, padmux, m_padmux);
    end
    apb(1'b0, 12'h004, 32'h0, rd, err, n);
    checks++;
    if (rd !== m_padmux || err !== 1'b0 || n !== 3) begin
      errors++;
      $display("FAIL padmux_read got rd=%h err=%b n=%0d want %h 0 3", rd, err, n, m_padmux);
    end
  endtask

  task automatic test_unmapped;
    int n;
    logic [31:0] rd;
    logic err;
    apb(1'b1, 12'h00C, 32'h1357_9BDF, rd, err, n);
    m_scratch = 32'h1357_9BDF;
    apb(1'b1, 12'h010, 32'hDEAD_BEEF, rd, err, n);
    checks++;
    if (err !== 1'b1 || padmux !== m_padmux) begin
      errors++;
      $display("FAIL unmapped_write got err=%b padmux=%h want 1 %h", err, padmux, m_padmux);
    end
    apb(1'b0, 12'h7FC, 32'h0, rd, err, n);
    checks++;
    if (rd !== 32'h0 || err !== 1'b1 || n !== 3) begin
      errors++;
      $display("FAIL unmapped_read got rd=%h err=%b n=%0d want 0 1 3", rd, err, n);
    end
    apb(1'b1, 12'h000, 32'h1111_2222, rd, err, n);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL info_write got err=%b want 1", err);
    end
    apb(1'b0, 12'h000, 32'h0, rd, err, n);
    checks++;
    if (rd !== CHIP_ID || err !== 1'b0) begin
      errors++;
      $display("FAIL info_after_write got rd=%h err=%b want %h 0", rd, err, CHIP_ID);
    end
    apb(1'b0, 12'h00C, 32'h0, rd, err, n);
    checks++;
    if (rd !== m_scratch || err !== 1'b0) begin
      errors++;
      $display("FAIL scratch_read got rd=%h err=%b want %h 0", rd, err, m_scratch);
    end
  endtask

  task automatic test_div_reprogram;
    int rel, n, idx;
    logic [31:0] rd;
    logic err;
    bit cleared;
    do_reset(rel);
    repeat (5) @(posedge clk);
    #1;
    apb(1'b1, 12'h008, 32'h0, rd, err, n);
    checks++;
    if (err !== 1'b0 || n !== 2 || div_busy !== 1'b1) begin
      errors++;
      $display("FAIL div_write got err=%b n=%0d busy=%b want 0 2 1", err, n, div_busy);
    end
    cleared = 0;
    for (int k = 0; k < 20; k++) begin
      if (!div_busy) begin
        cleared = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!cleared) begin
      errors++;
      $display("FAIL div_busy_clear got busy=1 want 0 within 20 cycles");
    end
    repeat (6) @(posedge clk);
    #1;
    idx = -1;
    foreach (pulse_q[j]) if (apply_q.size() == 1 && pulse_q[j] == apply_q[0]) idx = j;
    checks++;
    if (apply_q.size() !== 1 || idx < 1) begin
      errors++;
      $display("FAIL div_apply_count got applies=%0d idx=%0d want 1 applied after a prior pulse",
               apply_q.size(), idx);
    end else begin
      checks++;
      if (pulse_q[idx] - pulse_q[idx-1] !== 4) begin
        errors++;
        $display("FAIL div_inflight_period got %0d want 4", pulse_q[idx] - pulse_q[idx-1]);
      end
      checks++;
      if (pulse_q.size() - idx - 1 < 5) begin
        errors++;
        $display("FAIL div_new_pulses got %0d want >=5", pulse_q.size() - idx - 1);
      end
      for (int j = idx + 1; j < pulse_q.size(); j++) begin
        checks++;
        if (pulse_q[j] - pulse_q[j-1] !== 1) begin
          errors++;
          $display("FAIL div_new_period got %0d want 1", pulse_q[j] - pulse_q[j-1]);
        end
      end
    end
    apb(1'b0, 12'h008, 32'h0, rd, err, n);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL div_readback got rd=%h err=%b want 00000000 0", rd, err);
    end
  endtask

  task automatic test_back_to_back;
    int rel, n, p, nxt;
    logic [31:0] rd;
    logic err;
    do_reset(rel);
    p = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (clk_en) begin
        p = cyc;
        break;
      end
    end
    checks++;
    if (p < 0) begin
      errors++;
      $display("FAIL b2b_sync got no pulse want pulse within 20 cycles");
    end
    @(posedge clk); #1;
    apb(1'b1, 12'h008, 32'd9, rd, err, n);
    checks++;
    if (err !== 1'b0 || n !== 2) begin
      errors++;
      $display("FAIL b2b_first got err=%b n=%0d want 0 2", err, n);
    end
    apb(1'b1, 12'h008, 32'd1, rd, err, n);
    checks++;
    if (err !== 1'b0 || n !== 3) begin
      errors++;
      $display("FAIL b2b_second_stall got err=%b n=%0d want 0 3", err, n);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (apply_q.size() !== 2 || apply_q[0] !== p + 4 || apply_q[1] !== p + 14) begin
      errors++;
      $display("FAIL b2b_applies got n=%0d a0=%0d a1=%0d want 2 4 14", apply_q.size(),
               (apply_q.size() > 0) ? apply_q[0] - p : -1, (apply_q.size() > 1) ? apply_q[1] - p : -1);
    end
    nxt = -1;
    foreach (pulse_q[j]) if (nxt < 0 && pulse_q[j] > p + 14) nxt = pulse_q[j];
    checks++;
    if (nxt !== p + 16) begin
      errors++;
      $display("FAIL b2b_final_period got %0d want 16", nxt - p);
    end
    apb(1'b0, 12'h008, 32'h0, rd, err, n);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++;
      $display("FAIL b2b_readback got %h want 00000001", rd);
    end
  endtask

  task automatic test_async_reset;
    int n;
    logic [31:0] rd;
    logic err;
    apb(1'b1, 12'h004, 32'h1234_5678, rd, err, n);
    apb(1'b1, 12'h00C, 32'hCAFE_F00D, rd, err, n);
    apb(1'b1, 12'h008, 32'd7, rd, err, n);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pready !== 1'b1 || prdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL async_rdwait got pready=%b prdata=%h want 1 12345678", pready, prdata);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (pready !== 1'b0 || prdata !== 32'h0 || padmux !== 32'h0 || div_busy !== 1'b0 || clk_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got pready=%b prdata=%h padmux=%h busy=%b en=%b want 0 0 0 0 0",
               pready, prdata, padmux, div_busy, clk_en);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_padmux = 32'h0;
    m_scratch = 32'h0;
    apb(1'b0, 12'h00C, 32'h0, rd, err, n);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL async_scratch got %h want 00000000", rd);
    end
    apb(1'b0, 12'h008, 32'h0, rd, err, n);
    checks++;
    if (rd !== 32'h0000_0003) begin
      errors++;
      $display("FAIL async_clkdiv got %h want 00000003", rd);
    end
  endtask

  task automatic test_random;
    int rel, n, kind, exp_n;
    logic wr, exp_err;
    logic [11:0] a;
    logic [31:0] d, rd, exp_rd;
    logic err;
    do_reset(rel);
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 3);
      wr = 1'($urandom);
      d = $urandom;
      case (kind)
        0:       a = {8'h00, 2'd0, 2'($urandom)};
        1:       a = {8'h00, 2'd1, 2'($urandom)};
        2:       a = {8'h00, 2'd3, 2'($urandom)};
        default: a = 12'($urandom_range(16, 4095));
      endcase
      exp_err = (kind == 3) || (wr && kind == 0);
      exp_n = wr ? 2 : 3;
      exp_rd = 32'h0;
      if (!wr) begin
        if (kind == 0) exp_rd = CHIP_ID;
        else if (kind == 1) exp_rd = m_padmux;
        else if (kind == 2) exp_rd = m_scratch;
      end
      apb(wr, a, d, rd, err, n);
      if (wr && kind == 1) m_padmux = d;
      if (wr && kind == 2) m_scratch = d;
      checks++;
      if (err !== exp_err || n !== exp_n || (!wr && rd !== exp_rd)) begin
        errors++;
        $display("FAIL random_access addr=%h wr=%b got rd=%h err=%b n=%0d want rd=%h err=%b n=%0d",
                 a, wr, rd, err, n, exp_rd, exp_err, exp_n);
      end
      checks++;
      if (padmux !== m_padmux) begin
        errors++;
        $display("FAIL random_padmux got %h want %h", padmux, m_padmux);
      end
    end
  endtask

  initial begin
    test_reset();
    test_padmux();
    test_unmapped();
    test_div_reprogram();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
